// File: rtl/stream_ap_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_ap_arbiter_pkg
//  Description : Shared state encoding and index helper for the stream-apply
//                round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_ap_arbiter_pkg;

    // Arbiter state encoding: no grant, token offered to the ap, result pending
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Modulo-n add for requester indices; both operands are already < n
    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage : stream_ap_arbiter_pkg
`default_nettype wire

// File: rtl/stream_ap_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_pick
//  Description : Combinational round-robin pick. Returns the first asserted
//                request searching ptr, ptr+1, ... modulo N.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import stream_ap_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    int               w_pos;
    logic [IDX_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest asserted request wins
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_pos  = 0;
        w_cand = '0;
        for (int off = N - 1; off >= 0; off--) begin
            w_pos  = wrap_add(int'(ptr), off, N);
            w_cand = IDX_W'(w_pos);
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/stream_ap_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : stream_ap_arbiter
//  Description : Round-robin arbiter sharing one stream-apply primitive among
//                N requesters. One transaction in flight; the grant is held
//                from the input handshake through the result handshake so the
//                broadcast result is only ever marked valid to its owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_ap_arbiter
    import stream_ap_arbiter_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int RES_W  = 8
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [N-1:0]        req_in_valid,
    output logic [N-1:0]        req_in_ready,
    input  logic [N*DATA_W-1:0] req_in_data,
    output logic [N-1:0]        req_out_valid,
    input  logic [N-1:0]        req_out_ready,
    output logic [RES_W-1:0]    req_out_data,
    output logic                ap_in_valid,
    input  logic                ap_in_ready,
    output logic [DATA_W-1:0]   ap_in_data,
    input  logic                ap_out_valid,
    output logic                ap_out_ready,
    input  logic [RES_W-1:0]    ap_out_data,
    output logic [N-1:0]        grant,
    output logic                busy
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] w_ptr_inc;
    logic [IDX_W-1:0] w_pick_ptr;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_out_hs;
    logic [DATA_W-1:0] w_tok [N];

    // Unpack the flat token bus so the granted token is a plain array select
    for (genvar gi = 0; gi < N; gi++) begin : g_tok
        assign w_tok[gi] = req_in_data[gi*DATA_W +: DATA_W];
    end

    // Served requester becomes lowest priority: next search starts just past it
    assign w_ptr_inc = (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;

    // In WAIT the pick must already see the advanced pointer so the next
    // grant can be taken on the same edge as the result handshake
    assign w_pick_ptr = (r_state == ST_WAIT) ? w_ptr_inc : r_ptr;

    assign w_out_hs = ap_out_valid & req_out_ready[r_idx];

    rr_priority_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req_in_valid),
        .ptr (w_pick_ptr),
        .any (w_pick_any),
        .idx (w_pick_idx)
    );

    // State, round-robin pointer and current owner registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state: arbitration, issue handshake, slip recovery, completion
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_idx_nxt   = w_pick_idx;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Owner withdrew before the ap took the token: release the
                // grant without charging it a turn
                if (!req_in_valid[r_idx]) begin
                    w_state_nxt = ST_IDLE;
                end else if (ap_in_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_out_hs) begin
                    w_ptr_nxt = w_ptr_inc;
                    if (w_pick_any) begin
                        w_idx_nxt   = w_pick_idx;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake steering: only the owner sees ready/valid, all else held at 0
    always_comb begin
        req_in_ready  = '0;
        req_out_valid = '0;
        req_out_data  = '0;
        ap_in_valid   = 1'b0;
        ap_in_data    = '0;
        ap_out_ready  = 1'b0;
        grant         = '0;
        busy          = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                busy                = 1'b1;
                grant[r_idx]        = 1'b1;
                ap_in_valid         = req_in_valid[r_idx];
                ap_in_data          = w_tok[r_idx];
                req_in_ready[r_idx] = ap_in_ready;
            end
            ST_WAIT: begin
                busy                 = 1'b1;
                grant[r_idx]         = 1'b1;
                req_out_valid[r_idx] = ap_out_valid;
                ap_out_ready         = req_out_ready[r_idx];
                req_out_data         = ap_out_data;
            end
            default: begin
            end
        endcase
    end

endmodule : stream_ap_arbiter
`default_nettype wire

// File: tb/tb_stream_ap_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_ap_arbiter
//  Description : Directed testbench for stream_ap_arbiter with a small
//                behavioural apply primitive (result = token + 100, held
//                until accepted).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_ap_arbiter;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int RES_W  = 8;

    logic                clk = 1'b0;
    logic                nrst = 1'b0;
    logic [N-1:0]        req_in_valid = '0;
    logic [N-1:0]        req_in_ready;
    logic [N*DATA_W-1:0] req_in_data = '0;
    logic [N-1:0]        req_out_valid;
    logic [N-1:0]        req_out_ready = '1;
    logic [RES_W-1:0]    req_out_data;
    logic                ap_in_valid;
    logic                ap_in_ready;
    logic [DATA_W-1:0]   ap_in_data;
    logic                ap_out_valid;
    logic                ap_out_ready;
    logic [RES_W-1:0]    ap_out_data;
    logic [N-1:0]        grant;
    logic                busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Apply-primitive model
    logic       ap_en = 1'b1;
    logic       m_busy;
    logic       m_cnt;
    logic [7:0] m_res;

    assign ap_in_ready  = ap_en && !m_busy;
    assign ap_out_valid = m_busy && (m_cnt == 1'b0);
    assign ap_out_data  = ap_out_valid ? m_res : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_busy <= 1'b0;
            m_cnt  <= 1'b0;
            m_res  <= '0;
        end else if (!m_busy) begin
            if (ap_in_valid && ap_in_ready) begin
                m_busy <= 1'b1;
                m_cnt  <= 1'b1;
                m_res  <= ap_in_data + 8'd100;
            end
        end else if (m_cnt != 1'b0) begin
            m_cnt <= 1'b0;
        end else if (ap_out_ready) begin
            m_busy <= 1'b0;
        end
    end

    always #5 clk = ~clk;

    stream_ap_arbiter #(
        .N      (N),
        .DATA_W (DATA_W),
        .RES_W  (RES_W)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .req_in_valid  (req_in_valid),
        .req_in_ready  (req_in_ready),
        .req_in_data   (req_in_data),
        .req_out_valid (req_out_valid),
        .req_out_ready (req_out_ready),
        .req_out_data  (req_out_data),
        .ap_in_valid   (ap_in_valid),
        .ap_in_ready   (ap_in_ready),
        .ap_in_data    (ap_in_data),
        .ap_out_valid  (ap_out_valid),
        .ap_out_ready  (ap_out_ready),
        .ap_out_data   (ap_out_data),
        .grant         (grant),
        .busy          (busy)
    );

    task automatic set_tok(input int i, input logic [7:0] v);
        req_in_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst          = 1'b0;
        req_in_valid  = '0;
        req_out_ready = '1;
        req_in_data   = '0;
        ap_en         = 1'b1;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nrst = 1'b0;
        req_in_valid = 4'b1111;
        #1;
        n_checks++;
        if ({grant, busy, ap_in_valid, ap_out_ready, req_in_ready, req_out_valid} !== 15'd0)
            $display("FAIL reset_outputs: got grant=%b busy=%b aiv=%b aor=%b rir=%b rov=%b want all 0",
                     grant, busy, ap_in_valid, ap_out_ready, req_in_ready, req_out_valid);
        else n_pass++;
        do_reset();
        n_checks++;
        if ({grant, busy} !== 5'd0) $display("FAIL reset_release: got grant=%b busy=%b want 0", grant, busy);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        set_tok(2, 8'd5);
        req_in_valid = 4'b0100;
        #1;
        n_checks++;
        if ({grant, ap_in_valid} !== 5'd0) $display("FAIL t1_registered: got grant=%b aiv=%b want 0", grant, ap_in_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0100) $display("FAIL t1_grant: got %b want 0100", grant);
        else n_pass++;
        n_checks++;
        if ({ap_in_valid, ap_in_data, req_in_ready} !== {1'b1, 8'd5, 4'b0100})
            $display("FAIL t1_issue: got aiv=%b data=%0d rir=%b want 1 5 0100", ap_in_valid, ap_in_data, req_in_ready);
        else n_pass++;
        @(negedge clk);
        req_in_valid = '0;
        n_checks++;
        if ({busy, req_out_valid} !== 5'b1_0000) $display("FAIL t1_wait: got busy=%b rov=%b want 1 0000", busy, req_out_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({req_out_valid, req_out_data, ap_out_ready} !== {4'b0100, 8'd105, 1'b1})
            $display("FAIL t1_result: got rov=%b data=%0d aor=%b want 0100 105 1", req_out_valid, req_out_data, ap_out_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({grant, busy} !== 5'd0) $display("FAIL t1_idle: got grant=%b busy=%b want 0", grant, busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] gseq [5];
        logic [7:0]   dseq [5];
        int got;
        int idle;
        logic [N-1:0] g_exp;
        logic [7:0]   d_exp;
        do_reset();
        for (int i = 0; i < N; i++) set_tok(i, 8'(10 + i));
        req_in_valid = 4'b1111;
        got  = 0;
        idle = 0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            if (ap_in_valid && ap_in_ready) begin
                gseq[got] = grant;
                dseq[got] = ap_in_data;
                got++;
            end
            if (got >= 1 && got < 5 && !busy) idle++;
        end
        n_checks++;
        if (got !== 5) $display("FAIL t2_timeout: got %0d issues want 5", got);
        else n_pass++;
        for (int k = 0; k < got; k++) begin
            g_exp = 4'b0001 << (k % 4);
            d_exp = 8'(10 + (k % 4));
            n_checks++;
            if ({gseq[k], dseq[k]} !== {g_exp, d_exp})
                $display("FAIL t2_order[%0d]: got grant=%b data=%0d want %b %0d", k, gseq[k], dseq[k], g_exp, d_exp);
            else n_pass++;
        end
        n_checks++;
        if (idle !== 0) $display("FAIL t2_no_idle: got %0d idle cycles want 0", idle);
        else n_pass++;
        req_in_valid = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_hold_out_ready();
        do_reset();
        req_out_ready = 4'b1101;
        set_tok(1, 8'd21);
        req_in_valid = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0010) $display("FAIL t3_grant1: got %b want 0010", grant);
        else n_pass++;
        set_tok(0, 8'd20);
        set_tok(2, 8'd22);
        set_tok(3, 8'd23);
        req_in_valid = 4'b1111;
        @(negedge clk);
        req_in_valid = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({grant, ap_out_ready, ap_in_valid} !== {4'b0010, 1'b0, 1'b0})
                $display("FAIL t3_hold[%0d]: got grant=%b aor=%b aiv=%b want 0010 0 0", c, grant, ap_out_ready, ap_in_valid);
            else n_pass++;
            @(negedge clk);
        end
        req_out_ready = 4'b1111;
        #1;
        n_checks++;
        if ({ap_out_ready, req_out_valid, req_out_data} !== {1'b1, 4'b0010, 8'd121})
            $display("FAIL t3_release: got aor=%b rov=%b data=%0d want 1 0010 121", ap_out_ready, req_out_valid, req_out_data);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({grant, ap_in_data} !== {4'b0100, 8'd22})
            $display("FAIL t3_next: got grant=%b data=%0d want 0100 22", grant, ap_in_data);
        else n_pass++;
        req_in_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        set_tok(3, 8'd7);
        set_tok(0, 8'd9);
        req_in_valid = 4'b1000;
        @(negedge clk);
        n_checks++;
        if ({grant, ap_in_data} !== {4'b1000, 8'd7}) $display("FAIL t4_grant3: got grant=%b data=%0d want 1000 7", grant, ap_in_data);
        else n_pass++;
        @(negedge clk);
        req_in_valid = 4'b1001;
        @(negedge clk);
        n_checks++;
        if ({req_out_valid, req_out_data} !== {4'b1000, 8'd107})
            $display("FAIL t4_result: got rov=%b data=%0d want 1000 107", req_out_valid, req_out_data);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({grant, busy, ap_in_valid, ap_in_data} !== {4'b0001, 1'b1, 1'b1, 8'd9})
            $display("FAIL t4_wrap: got grant=%b busy=%b aiv=%b data=%0d want 0001 1 1 9", grant, busy, ap_in_valid, ap_in_data);
        else n_pass++;
        req_in_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_slip();
        do_reset();
        ap_en = 1'b0;
        req_in_valid = 4'b0100;
        @(negedge clk);
        n_checks++;
        if ({grant, ap_in_valid, req_in_ready} !== {4'b0100, 1'b1, 4'b0000})
            $display("FAIL t5_issue: got grant=%b aiv=%b rir=%b want 0100 1 0000", grant, ap_in_valid, req_in_ready);
        else n_pass++;
        req_in_valid = '0;
        @(negedge clk);
        n_checks++;
        if ({grant, busy} !== 5'd0) $display("FAIL t5_idle: got grant=%b busy=%b want 0", grant, busy);
        else n_pass++;
        req_in_valid = 4'b1100;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0100) $display("FAIL t5_regrant: got %b want 0100", grant);
        else n_pass++;
        req_in_valid = '0;
        @(negedge clk);
        ap_en = 1'b1;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_in_valid = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        req_in_valid = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0010) $display("FAIL t6_grant1: got %b want 0010", grant);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy, grant} !== {1'b1, 4'b0010}) $display("FAIL t6_wait: got busy=%b grant=%b want 1 0010", busy, grant);
        else n_pass++;
        nrst = 1'b0;
        #1;
        n_checks++;
        if ({grant, busy, ap_in_valid, ap_out_ready, req_in_ready, req_out_valid} !== 15'd0)
            $display("FAIL t6_async: got grant=%b busy=%b aiv=%b aor=%b rir=%b rov=%b want all 0",
                     grant, busy, ap_in_valid, ap_out_ready, req_in_ready, req_out_valid);
        else n_pass++;
        req_in_valid = 4'b1111;
        @(negedge clk);
        nrst = 1'b1;
        #1;
        n_checks++;
        if (grant !== 4'b0000) $display("FAIL t6_idle: got %b want 0000", grant);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0001) $display("FAIL t6_ptr0: got %b want 0001", grant);
        else n_pass++;
        req_in_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_out_ready();
        test_wrap();
        test_slip();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_stream_ap_arbiter
`default_nettype wire
